// File: rtl/equiv_run_ctrl.sv
// equiv_run_ctrl: bounded run controller for a dual-instance equivalence harness.
// Generates LFSR stimulus for both instances, compares their 91-bit outputs
// LAT cycles later, and reports pass, a saturating mismatch count and the
// index of the first failing vector.
// Optional build macro: EQUIV_STOP_ON_FAIL_EN -- the first mismatch ends the run.

module equiv_run_ctrl #(
  parameter int unsigned NUM_VEC = 1024,
  parameter int unsigned LAT     = 1,
  parameter logic [71:0] SEED    = 72'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [20:0] wire0,
  output logic [13:0] wire1,
  output logic [20:0] wire2,
  output logic [15:0] wire3,
  output logic        stim_valid,
  input  logic [90:0] y_1,
  input  logic [90:0] y_2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_cnt,
  output logic [15:0] first_fail_idx
);

  localparam int unsigned STIM_W = 72;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DCNT_W = 4;

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [STIM_W-1:0] SEED_EFF   = (SEED == '0) ? STIM_W'(1) : SEED;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_VEC - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'((LAT == 0) ? 0 : LAT - 1);
  localparam logic [IDX_W-1:0]  NO_FAIL    = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [STIM_W-1:0]   r_stim;
  logic                r_stim_valid;
  logic [IDX_W-1:0]    r_idx;
  logic [DCNT_W-1:0]   r_drain_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [CNT_W-1:0]    r_mismatch_cnt;
  logic [IDX_W-1:0]    r_first_fail;

  logic [STIM_W-1:0]   w_lfsr_nxt;
  logic                w_cmp_vld;
  logic [IDX_W-1:0]    w_cmp_idx;
  logic                w_cmp_en;
  logic                w_miss;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_stop;
  logic                w_last_vec;
  logic                w_drain_end;
  logic                w_to_done;

  // LFSR step: shift left, feedback from taps 71, 65, 24, 18.
  assign w_lfsr_nxt = {r_stim[70:0], r_stim[71] ^ r_stim[65] ^ r_stim[24] ^ r_stim[18]};

  // Compare source: either the live drive slot or the end of the delay line.
  generate
    if (LAT == 0) begin : g_lat0
      assign w_cmp_vld = r_stim_valid;
      assign w_cmp_idx = r_idx;
    end else begin : g_pipe
      logic [LAT-1:0]            r_pipe_vld;
      logic [LAT-1:0][IDX_W-1:0] r_pipe_idx;

      // LAT-deep delay line carrying {stim_valid, index} to the compare point.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe_vld <= '0;
          r_pipe_idx <= '0;
        end else if (w_stop) begin
          r_pipe_vld <= '0;
        end else begin
          r_pipe_vld[0] <= r_stim_valid;
          r_pipe_idx[0] <= r_idx;
          for (int i = 1; i < int'(LAT); i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_idx[i] <= r_pipe_idx[i-1];
          end
        end
      end

      assign w_cmp_vld = r_pipe_vld[LAT-1];
      assign w_cmp_idx = r_pipe_idx[LAT-1];
    end
  endgenerate

  // Compares only count while a run is active; anything in flight at DONE is dropped.
  assign w_cmp_en  = w_cmp_vld && ((r_state == ST_DRIVE) || (r_state == ST_DRAIN));
  assign w_miss    = w_cmp_en && (y_1 != y_2);
  assign w_cnt_nxt = (w_miss && (r_mismatch_cnt != CNT_MAX)) ? r_mismatch_cnt + CNT_W'(1)
                                                              : r_mismatch_cnt;

`ifdef EQUIV_STOP_ON_FAIL_EN
  assign w_stop = w_miss;
`else
  assign w_stop = 1'b0;
`endif

  // Run termination conditions.
  assign w_last_vec  = (r_state == ST_DRIVE) && (r_idx == LAST_IDX);
  assign w_drain_end = (r_state == ST_DRAIN) && (r_drain_cnt == DRAIN_LAST);
  assign w_to_done   = w_stop || (w_last_vec && (LAT == 0)) || w_drain_end;

  // Run FSM with registered stimulus, status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_stim         <= SEED_EFF;
      r_stim_valid   <= 1'b0;
      r_idx          <= '0;
      r_drain_cnt    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_mismatch_cnt <= '0;
      r_first_fail   <= NO_FAIL;
    end else begin
      r_done         <= 1'b0;
      r_mismatch_cnt <= w_cnt_nxt;
      if (w_miss && (r_first_fail == NO_FAIL)) begin
        r_first_fail <= w_cmp_idx;
      end

      if (w_to_done) begin
        // pass reflects any mismatch found on this final compare as well.
        r_state      <= ST_DONE;
        r_done       <= 1'b1;
        r_busy       <= 1'b0;
        r_stim_valid <= 1'b0;
        r_pass       <= (w_cnt_nxt == '0);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state        <= ST_DRIVE;
              r_stim         <= SEED_EFF;
              r_stim_valid   <= 1'b1;
              r_idx          <= '0;
              r_busy         <= 1'b1;
              r_pass         <= 1'b0;
              r_mismatch_cnt <= '0;
              r_first_fail   <= NO_FAIL;
            end
          end
          ST_DRIVE: begin
            if (w_last_vec) begin
              // Last vector stays on the wires through the drain.
              r_state      <= ST_DRAIN;
              r_stim_valid <= 1'b0;
              r_drain_cnt  <= '0;
            end else begin
              r_idx  <= r_idx + IDX_W'(1);
              r_stim <= w_lfsr_nxt;
            end
          end
          ST_DRAIN: begin
            r_drain_cnt <= r_drain_cnt + DCNT_W'(1);
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign wire0          = r_stim[71:51];
  assign wire1          = r_stim[50:37];
  assign wire2          = r_stim[36:16];
  assign wire3          = r_stim[15:0];
  assign stim_valid     = r_stim_valid;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign mismatch_cnt   = r_mismatch_cnt;
  assign first_fail_idx = r_first_fail;

endmodule

// File: tb/tb_equiv_run_ctrl.sv
// Scoreboard bench for equiv_run_ctrl. Three instances cover LAT=1/NUM_VEC=8,
// LAT=2/NUM_VEC=16 with injected mismatches, and LAT=0/NUM_VEC=1 with a zero seed.
// Expected values follow EQUIV_STOP_ON_FAIL_EN when it is defined.

module tb_equiv_run_ctrl;

  localparam int NDUT = 3;

  typedef struct {
    int          id;
    int          cyc;
    logic        pass;
    logic [15:0] cnt;
    logic [15:0] ffi;
  } res_t;

  typedef struct {
    int          id;
    logic [71:0] v;
  } vec_t;

  typedef struct {
    int          id;
    int          cyc;
    logic        busy;
    logic        valid;
    logic [71:0] stim;
    logic        pass;
    logic [15:0] cnt;
    logic [15:0] ffi;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  logic        fin_req = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        start_v [NDUT];
  logic [20:0] w0      [NDUT];
  logic [13:0] w1      [NDUT];
  logic [20:0] w2      [NDUT];
  logic [15:0] w3      [NDUT];
  logic        valid_v [NDUT];
  logic        busy_v  [NDUT];
  logic        done_v  [NDUT];
  logic        pass_v  [NDUT];
  logic [15:0] cnt_v   [NDUT];
  logic [15:0] ffi_v   [NDUT];
  logic [90:0] y1_v    [NDUT];
  logic [90:0] y2_v    [NDUT];
  int          flip_a  [NDUT];
  int          flip_b  [NDUT];

  res_t  res_q [$];
  vec_t  vec_q [$];
  snap_t snap_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance outputs agree except bit 90 of y_2 in scheduled cycles.
  for (genvar g = 0; g < NDUT; g++) begin : g_y
    assign y1_v[g] = {27'h5a5a5a5, 32'(cyc), 32'(cyc * 3)};
    assign y2_v[g] = y1_v[g] ^ {((cyc == flip_a[g]) || (cyc == flip_b[g])), 90'h0};
  end

  equiv_run_ctrl #(.NUM_VEC(8), .LAT(1), .SEED(72'h1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .wire0(w0[0]), .wire1(w1[0]), .wire2(w2[0]), .wire3(w3[0]), .stim_valid(valid_v[0]),
    .y_1(y1_v[0]), .y_2(y2_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .mismatch_cnt(cnt_v[0]), .first_fail_idx(ffi_v[0])
  );

  equiv_run_ctrl #(.NUM_VEC(16), .LAT(2), .SEED(72'h1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .wire0(w0[1]), .wire1(w1[1]), .wire2(w2[1]), .wire3(w3[1]), .stim_valid(valid_v[1]),
    .y_1(y1_v[1]), .y_2(y2_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .mismatch_cnt(cnt_v[1]), .first_fail_idx(ffi_v[1])
  );

  equiv_run_ctrl #(.NUM_VEC(1), .LAT(0), .SEED(72'h0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .wire0(w0[2]), .wire1(w1[2]), .wire2(w2[2]), .wire3(w3[2]), .stim_valid(valid_v[2]),
    .y_1(y1_v[2]), .y_2(y2_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .mismatch_cnt(cnt_v[2]), .first_fail_idx(ffi_v[2])
  );

  function automatic logic [71:0] lfsr(input logic [71:0] s);
    return {s[70:0], s[71] ^ s[65] ^ s[24] ^ s[18]};
  endfunction

  task automatic chk(input string name, input int id, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, id, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a vector, a done pulse or a snapshot point.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (valid_v[i]) begin
        if (vec_q.size() == 0) begin
          chk("stim_unexpected", i, 72'(valid_v[i]), 72'(0));
        end else begin
          vec_t v;
          v = vec_q.pop_front();
          chk("stim_owner", i, 72'(i), 72'(v.id));
          chk("stim", i, {w0[i], w1[i], w2[i], w3[i]}, v.v);
          chk("wire3", i, 72'(w3[i]), 72'(v.v[15:0]));
        end
      end
      if (done_v[i]) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", i, 72'(done_v[i]), 72'(0));
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("done_owner", i, 72'(i), 72'(r.id));
          chk("done_cycle", i, 72'(cyc), 72'(r.cyc));
          chk("pass", i, 72'(pass_v[i]), 72'(r.pass));
          chk("mismatch_cnt", i, 72'(cnt_v[i]), 72'(r.cnt));
          chk("first_fail_idx", i, 72'(ffi_v[i]), 72'(r.ffi));
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      snap_t s;
      s = snap_q.pop_front();
      chk("snap_busy", s.id, 72'(busy_v[s.id]), 72'(s.busy));
      chk("snap_valid", s.id, 72'(valid_v[s.id]), 72'(s.valid));
      chk("snap_stim", s.id, {w0[s.id], w1[s.id], w2[s.id], w3[s.id]}, s.stim);
      chk("snap_pass", s.id, 72'(pass_v[s.id]), 72'(s.pass));
      chk("snap_cnt", s.id, 72'(cnt_v[s.id]), 72'(s.cnt));
      chk("snap_ffi", s.id, 72'(ffi_v[s.id]), 72'(s.ffi));
    end
    if (fin_req) begin
      chk("pending_results", 0, 72'(res_q.size()), 72'(0));
      chk("pending_vectors", 0, 72'(vec_q.size()), 72'(0));
      chk("pending_snapshots", 0, 72'(snap_q.size()), 72'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic push_snap(input int id, input int c, input logic b, input logic v,
                           input logic [71:0] st, input logic p, input logic [15:0] cn,
                           input logic [15:0] f);
    snap_t s;
    s.id = id; s.cyc = c; s.busy = b; s.valid = v; s.stim = st;
    s.pass = p; s.cnt = cn; s.ffi = f;
    snap_q.push_back(s);
  endtask

  // Pulse start for one cycle and queue the vectors and result the run should produce.
  task automatic launch(input int id, input int lat, input int ka, input int kb,
                        input int ndrv, input logic push_res, input int done_off,
                        input logic p, input logic [15:0] cn, input logic [15:0] f,
                        output int t0);
    vec_t        v;
    res_t        r;
    logic [71:0] s;
    @(posedge clk);
    #1;
    t0 = cyc;
    flip_a[id] = (ka < 0) ? -1 : t0 + 1 + ka + lat;
    flip_b[id] = (kb < 0) ? -1 : t0 + 1 + kb + lat;
    start_v[id] = 1'b1;
    s = 72'h1;
    for (int k = 0; k < ndrv; k++) begin
      v.id = id;
      v.v  = s;
      vec_q.push_back(v);
      s = lfsr(s);
    end
    if (push_res) begin
      r.id = id; r.cyc = t0 + done_off; r.pass = p; r.cnt = cn; r.ffi = f;
      res_q.push_back(r);
    end
    @(posedge clk);
    #1;
    start_v[id] = 1'b0;
  endtask

  task automatic wait_results();
    for (int n = 0; n < 300 && res_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      start_v[i] = 1'b0;
      flip_a[i]  = -1;
      flip_b[i]  = -1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) push_snap(i, cyc, 1'b0, 1'b0, 72'h1, 1'b0, 16'h0, 16'hFFFF);
    repeat (2) @(posedge clk);

    // Clean run: 8 vectors from seed 1, done 10 cycles after start.
    launch(0, 1, -1, -1, 8, 1'b1, 10, 1'b1, 16'h0, 16'hFFFF, t0);
    push_snap(0, t0 + 3, 1'b1, 1'b1, 72'h4, 1'b0, 16'h0, 16'hFFFF);
    wait_results();

    // start pulsed mid-run is ignored; done keeps its original cycle.
    launch(0, 1, -1, -1, 8, 1'b1, 10, 1'b1, 16'h0, 16'hFFFF, t0);
    repeat (3) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_results();

    // Reset while vector 3 is driven: back to idle values, no done pulse.
    launch(0, 1, -1, -1, 3, 1'b0, 0, 1'b0, 16'h0, 16'h0, t0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    push_snap(0, t0 + 5, 1'b0, 1'b0, 72'h1, 1'b0, 16'h0, 16'hFFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);

    // A fresh run after the abort completes normally.
    launch(0, 1, -1, -1, 8, 1'b1, 10, 1'b1, 16'h0, 16'hFFFF, t0);
    wait_results();

    // LAT=2, mismatches on indices 5 and 9.
`ifdef EQUIV_STOP_ON_FAIL_EN
    launch(1, 2, 5, 9, 8, 1'b1, 9, 1'b0, 16'd1, 16'd5, t0);
`else
    launch(1, 2, 5, 9, 16, 1'b1, 19, 1'b0, 16'd2, 16'd5, t0);
`endif
    wait_results();

    // LAT=0, single vector with a mismatch; zero seed runs as seed 1.
    launch(2, 0, 0, -1, 1, 1'b1, 2, 1'b0, 16'd1, 16'd0, t0);
    wait_results();

    fin_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor did not finish the run");
    $fatal(1);
  end

endmodule
